// File: rtl/arkanoid_pkg.sv
// Shared Arkanoid geometry constants and the brick-scan FSM encoding.
// The ball mover and renderer import the same constants.
package arkanoid_pkg;

  localparam int NUM_BRICKS = 16;
  localparam int BRICK_W    = 64;
  localparam int BRICK_H    = 20;
  localparam int ROW_Y      = 100;
  localparam int BALL_R     = 10;
  localparam int SCREEN_W   = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_HOLD
  } scan_state_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/brick_contact.sv
// Combinational contact test of the ball's left/right edge against one brick.
// Arithmetic is 13-bit unsigned so x+R and face positions never wrap.
module brick_contact
  import arkanoid_pkg::*;
#(
  parameter int BRICK_W = arkanoid_pkg::BRICK_W,
  parameter int ROW_Y   = arkanoid_pkg::ROW_Y,
  parameter int BRICK_H = arkanoid_pkg::BRICK_H,
  parameter int BALL_R  = arkanoid_pkg::BALL_R
) (
  input  logic [11:0] x_pos,
  input  logic [11:0] y_pos,
  input  logic [3:0]  idx,
  input  logic        alive,
  output logic        hit
);

  logic [12:0] x13, y13, face_left, face_right;
  logic        in_row, on_left, on_right;

  assign x13        = {1'b0, x_pos};
  assign y13        = {1'b0, y_pos};
  assign face_left  = 13'(idx) * 13'(BRICK_W);
  assign face_right = face_left + 13'(BRICK_W - 1);

  assign in_row   = (y13 + 13'(BALL_R) >= 13'(ROW_Y)) &&
                    (y13 <= 13'(ROW_Y + BRICK_H - 1 + BALL_R));
  assign on_left  = (x13 + 13'(BALL_R) == face_left);
  // Guard keeps x-R from underflowing near the left screen edge.
  assign on_right = (x13 >= 13'(BALL_R)) && (x13 - 13'(BALL_R) == face_right);

  assign hit = alive && in_row && (on_left || on_right);

endmodule

// File: rtl/brick_collision_x.sv
// Brick-row horizontal collision detector: rescans all 16 bricks on every
// ball X change, holds the one-hot hit report and retires hit bricks.
module brick_collision_x
  import arkanoid_pkg::*;
#(
  parameter int BRICK_W = arkanoid_pkg::BRICK_W,
  parameter int ROW_Y   = arkanoid_pkg::ROW_Y,
  parameter int BRICK_H = arkanoid_pkg::BRICK_H,
  parameter int BALL_R  = arkanoid_pkg::BALL_R
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        restart,
  input  logic [11:0] x_pos,
  input  logic [11:0] y_pos,
  output logic [15:0] collision_det,
  output logic [15:0] bricks_alive,
  output logic [4:0]  hit_count,
  output logic        all_cleared
);

  scan_state_t state, next_state;
  logic [11:0] x_prev;
  logic [3:0]  idx;
  logic [15:0] hits, hits_next;
  logic        moved, last, hit, commit;
  logic [5:0]  count_sum;

  assign moved = (x_pos != x_prev);
  assign last  = (idx == 4'd15);

  brick_contact #(
    .BRICK_W(BRICK_W),
    .ROW_Y  (ROW_Y),
    .BRICK_H(BRICK_H),
    .BALL_R (BALL_R)
  ) u_contact (
    .x_pos(x_pos),
    .y_pos(y_pos),
    .idx  (idx),
    .alive(bricks_alive[idx]),
    .hit  (hit)
  );

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
  always_comb begin
    next_state = state;
    if (restart || moved) next_state = ST_SCAN;
    else if (state == ST_SCAN && last) next_state = ST_HOLD;
  end

  always_comb begin
    hits_next = hits | (16'(hit) << idx);
    commit    = (state == ST_SCAN) && last && !moved && !restart;
    count_sum = 6'(hit_count) + 6'(popcount16(hits_next));
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      x_prev        <= 12'hFFF;
      idx           <= '0;
      hits          <= '0;
      collision_det <= '0;
      bricks_alive  <= 16'hFFFF;
      hit_count     <= '0;
      all_cleared   <= 1'b0;
    end else begin
      x_prev      <= x_pos;
      all_cleared <= (bricks_alive == '0);
      if (restart) begin
        bricks_alive  <= 16'hFFFF;
        hit_count     <= '0;
        collision_det <= '0;
        idx           <= '0;
        hits          <= '0;
      end else if (moved) begin
        // A move mid-scan discards the partial result and starts over.
        idx           <= '0;
        hits          <= '0;
        collision_det <= '0;
      end else if (state == ST_SCAN) begin
        hits <= hits_next;
        idx  <= idx + 4'd1;
        if (commit) begin
          collision_det <= hits_next;
          bricks_alive  <= bricks_alive & ~hits_next;
          hit_count     <= (count_sum > 6'd16) ? 5'd16 : count_sum[4:0];
        end
      end
    end
  end

endmodule

// File: doc/brick_collision_x.md
# brick_collision_x

Horizontal collision detector for the Arkanoid brick row; it produces the `collision_det` vector consumed by the ball X-motion block. On every change of ball X position it scans the 16 bricks in sequence and reports which live brick the ball's left or right edge touches. It holds that report until the ball moves, and retires hit bricks. It sits between the ball position registers and the ball X mover, and feeds brick state to the renderer.

## Interface
Parameters:
- `NUM_BRICKS`, 16: bricks in the row; fixed by the 16-bit `collision_det`.
- `BRICK_W`, 64: brick width in px. Brick i spans x = i*64 .. i*64+63.
- `ROW_Y`, 100: top y of the brick row.
- `BRICK_H`, 20: row height. The row spans y = 100..119.
- `BALL_R`, 10: ball half-size, matching the mover's ±10 edge offset.

Ports (one clock; reset is synchronous and active-high):
- `pclk` in 1: pixel clock.
- `reset` in 1: synchronous, active-high.
- `restart` in 1: level restart pulse. Restores all bricks and clears `hit_count`.
- `x_pos` in 12: ball centre X from the mover.
- `y_pos` in 12: ball centre Y.
- `collision_det` out 16: one-hot hit brick; 0 means no hit. Registered.
- `bricks_alive` out 16: bit i = brick i present. Registered.
- `hit_count` out 5: bricks destroyed, saturating at 16.
- `all_cleared` out 1: high when `bricks_alive == 0`. Registered.

## Operation
- Internal state: `x_prev` (12b), `idx` (4b), `hits` (16b), FSM state.
- FSM states and transitions:
  - IDLE: go to SCAN when `x_pos != x_prev`.
  - SCAN: evaluate brick `idx` each cycle, with `idx` running 0..15. After `idx` 15 go to HOLD.
  - HOLD: go to SCAN when `x_pos != x_prev`.
- Change detection: `x_prev <= x_pos` every cycle. A difference starts a scan on the next cycle with `idx=0` and `hits=0`, and `collision_det` clears to 0 on that same edge.
- Contact test for brick i, all arithmetic in 13-bit unsigned with no wrap:
  - Brick must be alive.
  - Vertical: `y_pos+BALL_R >= ROW_Y` and `y_pos <= ROW_Y+BRICK_H-1+BALL_R`.
  - Horizontal: `x_pos+BALL_R == i*BRICK_W` (left face) or `x_pos >= BALL_R` and `x_pos-BALL_R == i*BRICK_W+BRICK_W-1` (right face).
- Geometry allows at most one hit per position.
- Commit on the SCAN→HOLD edge:
  - `collision_det <= hits`.
  - `bricks_alive <= bricks_alive & ~hits`.
  - `hit_count` += popcount(hits), saturating at 16.
- `collision_det` holds in HOLD until `x_pos` changes. The mover samples it only on its own tick, so the level must persist.
- Abort: an `x_pos` change during SCAN restarts at `idx=0` with `hits=0`. Nothing is committed from the aborted scan.
- `restart`, any state:
  - `bricks_alive <= 16'hFFFF`, `hit_count <= 0`, `collision_det <= 0`.
  - FSM goes to SCAN at `idx=0`.
  - `restart` beats a simultaneous commit.
- `reset` has priority over `restart`.

## Timing
- Reset values:
  - `collision_det=0`, `bricks_alive=16'hFFFF`, `hit_count=0`, `all_cleared=0`.
  - FSM=IDLE, `x_prev=12'hFFF`, so the first real `x_pos` triggers a scan.
- Latency: `x_pos` changes before edge N. SCAN occupies edges N+1..N+16 and commits at N+16. `collision_det` is valid after edge N+16 (17 cycles incl. detect).
- `all_cleared` lags `bricks_alive` by one cycle.
- Scan time (17 cycles) is negligible against the mover period (800_000 cycles), so no backpressure is needed.

## Structure
- Shared package `arkanoid_pkg`: `NUM_BRICKS`, `BRICK_W`, `BRICK_H`, `ROW_Y`, `BALL_R`, screen width 1024. The ball mover and renderer use the same constants.
- Sub-module `brick_contact`: combinational contact test for one index (`x_pos`, `y_pos`, `idx`, `alive` → `hit`). It is instantiated once and time-multiplexed by `idx`.
- Top level holds the FSM, `hits` accumulator, commit logic and counters.

## Test plan
- Reset, then `y_pos=105`, `x_pos=118` (118+10=128, left face of brick 2) → after 17 cycles `collision_det=16'h0004`, `bricks_alive=16'hFFFB`, `hit_count=1`.
- Then `x_pos=117` → `collision_det=0` on the next edge. Rescan gives 0. Returning to `x_pos=118` gives 0 because brick 2 is dead.
- `y_pos=105`, `x_pos=137` (137-10=127, right face of brick 1) → `collision_det=16'h0002`. `y_pos=200` at any x → always 0.
- Change `x_pos` from 118 to 119 and back to 118 during SCAN → the first scan aborts, there is exactly one commit, and `hit_count` increments by 1, not 2.
- Kill all 16 bricks one by one → `hit_count=16` and `all_cleared=1` one cycle after the final commit. A further hit attempt leaves `hit_count` at 16.
- `restart` asserted on the commit edge → `bricks_alive=16'hFFFF`, `hit_count=0`, `collision_det=0`, and a new scan starts.
